// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- multi-cycle ALU for the calculator datapath
//
// Add/sub complete in one cycle, multiply is an iterative shift-add (one
// multiplier bit per cycle), divide is an iterative restoring divider (one
// quotient bit per cycle). Results and flags are registered and held until
// the next completed operation.
//
// Handshake: start is sampled only while busy=0 (IDLE). When sampled high,
// x/y/s are captured and busy rises on the next cycle. Exactly one done pulse
// follows each accepted operation (unless rst intervenes); z/v/dz change only
// in that done cycle. start may be raised again in the done cycle itself.
//
// Parameters
//   W      operand/result width (W >= 4)
//   CNT_W  iteration counter width, 2**CNT_W > W
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   operation request
//   x, y   in   operands A and B (W bits)
//   s      in   op select: 00 add, 01 sub, 10 mul, 11 div
//   z      out  result (W bits), registered
//   v      out  overflow / invalid flag, registered
//   dz     out  divide-by-zero flag, registered
//   busy   out  operation in flight
//   done   out  one-cycle completion pulse
//
// Build option: define ALU_SAT_EN to saturate add/sub/mul results on
// overflow instead of wrapping. Divide is unaffected.
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter int W     = 18,
   parameter int CNT_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [1:0]   s,
   output logic [W-1:0] z,
   output logic         v,
   output logic         dz,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, ADDSUB, MUL, DIV} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   state_t           state, state_next;
   logic [W-1:0]     a, b;        // captured operands
   logic             op_sub;      // add/sub select captured at accept
   logic [CNT_W-1:0] cnt;
   // Shared iteration register: {high half, low half}.
   //   MUL: {partial product, remaining multiplier bits}
   //   DIV: {partial remainder, dividend bits not yet consumed / quotient}
   logic [2*W-1:0]   p;

   logic             last, div_zero, finish;

   // add/sub
   logic [W-1:0]     bb, sum, sat_val;
   logic             ovf_as;
   // multiply step
   logic [W:0]       mul_sum;
   logic [2*W-1:0]   mul_next;
   logic             mul_ovf;
   // divide step
   logic [W:0]       div_shift, div_diff;
   logic             div_ge;
   logic [W-1:0]     div_rem;
   logic [2*W-1:0]   div_next;
   // result to be registered on finish
   logic [W-1:0]     res_z;
   logic             res_v, res_dz;

   assign busy     = (state != IDLE);
   assign last     = (cnt == LAST);
   assign div_zero = (b == '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (s)
                  2'b10:   state_next = MUL;
                  2'b11:   state_next = DIV;
                  default: state_next = ADDSUB;
               endcase
            end
         end
         ADDSUB: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         MUL: begin
            if (last) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         DIV: begin
            // A zero divisor finishes on the first cycle without iterating.
            if (div_zero || last) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- arithmetic ----------------
   always_comb begin
      // Subtraction is a + ~b + 1; overflow when the effective operands share
      // a sign and the sum's sign differs from it.
      bb      = op_sub ? ~b : b;
      sum     = a + bb + W'(op_sub);
      ovf_as  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
      sat_val = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

      // Shift-add: add multiplicand into the high half when the current
      // multiplier LSB is set, then shift the whole register right.
      mul_sum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
      mul_next = {mul_sum, p[W-1:1]};
      mul_ovf  = |mul_next[2*W-1:W];

      // Restoring step: shift next dividend bit into the remainder, subtract
      // the divisor if it fits, shift the quotient bit into the low half.
      div_shift = {p[2*W-1:W], p[W-1]};
      div_diff  = div_shift - {1'b0, b};
      div_ge    = (div_shift >= {1'b0, b});
      div_rem   = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      div_next  = {div_rem, p[W-2:0], div_ge};
   end

   always_comb begin
      res_z  = '0;
      res_v  = 1'b0;
      res_dz = 1'b0;
      case (state)
         ADDSUB: begin
            res_v = ovf_as;
`ifdef ALU_SAT_EN
            res_z = ovf_as ? sat_val : sum;
`else
            res_z = sum;
`endif
         end
         MUL: begin
            res_v = mul_ovf;
`ifdef ALU_SAT_EN
            res_z = mul_ovf ? {W{1'b1}} : mul_next[W-1:0];
`else
            res_z = mul_next[W-1:0];
`endif
         end
         DIV: begin
            if (div_zero) begin
               res_z  = {W{1'b1}};
               res_v  = 1'b1;
               res_dz = 1'b1;
            end else begin
               res_z  = div_next[W-1:0];
            end
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a      <= '0;
         b      <= '0;
         op_sub <= 1'b0;
         cnt    <= '0;
         p      <= '0;
         z      <= '0;
         v      <= 1'b0;
         dz     <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= finish;

         if (state == IDLE && start) begin
            a      <= x;
            b      <= y;
            op_sub <= s[0];
            cnt    <= '0;
            // mul iterates over y's bits; div consumes x's bits.
            p      <= (s == 2'b10) ? {{W{1'b0}}, y} : {{W{1'b0}}, x};
         end

         if (state == MUL) begin
            p   <= mul_next;
            cnt <= last ? '0 : cnt + CNT_W'(1);
         end

         if (state == DIV && !div_zero) begin
            p   <= div_next;
            cnt <= last ? '0 : cnt + CNT_W'(1);
         end

         if (finish) begin
            z  <= res_z;
            v  <= res_v;
            dz <= res_dz;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- scoreboard bench for seq_alu (W=18).
// Driver tasks push {dz,v,z} and the expected done cycle on issue; a monitor
// pops and compares on every done pulse. Random operations are checked
// against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu;
   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] x, y;
   logic [1:0]   s;
   logic [W-1:0] z;
   logic         v, dz, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W+1:0] exp_q[$];   // {dz, v, z}
   int           cyc_q[$];   // posedge count at which done must be visible

   seq_alu #(.W(W), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .s(s),
      .z(z), .v(v), .dz(dz), .busy(busy), .done(done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   task automatic model(input logic [1:0] op, input logic [W-1:0] xx, yy,
                        output logic [W+1:0] e, output int lat);
      longint sx, sy, r, maxs, mins;
      logic [W-1:0] zz;
      logic vv, dd;
      maxs = (longint'(1) << (W-1)) - 1;
      mins = -(longint'(1) << (W-1));
      vv = 1'b0; dd = 1'b0; zz = '0; lat = W;
      case (op)
         2'b00, 2'b01: begin
            sx = xx[W-1] ? longint'(xx) - (longint'(1) << W) : longint'(xx);
            sy = yy[W-1] ? longint'(yy) - (longint'(1) << W) : longint'(yy);
            r  = (op == 2'b00) ? sx + sy : sx - sy;
            vv = (r > maxs) || (r < mins);
            zz = r[W-1:0];
`ifdef ALU_SAT_EN
            if (vv) zz = (r > 0) ? maxs[W-1:0] : mins[W-1:0];
`endif
            lat = 1;
         end
         2'b10: begin
            r  = longint'(xx) * longint'(yy);
            vv = (r >> W) != 0;
            zz = r[W-1:0];
`ifdef ALU_SAT_EN
            if (vv) zz = '1;
`endif
         end
         default: begin
            if (yy == 0) begin
               zz = '1; vv = 1'b1; dd = 1'b1; lat = 1;
            end else begin
               zz = xx / yy;
            end
         end
      endcase
      e = {dd, vv, zz};
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL idle_timeout busy=%0b required=0", busy);
      end
   endtask

   // Issue with an explicitly stated expectation (always called at a negedge).
   task automatic issue_k(input logic [1:0] op, input logic [W-1:0] xx, yy,
                          input logic [W+1:0] e, input int lat);
      wait_idle();
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 1 + lat);
      start = 1'b1; s = op; x = xx; y = yy;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue_r(input logic [1:0] op, input logic [W-1:0] xx, yy);
      logic [W+1:0] e;
      int lat;
      model(op, xx, yy, e, lat);
      issue_k(op, xx, yy, e, lat);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return {1'b0, {(W-1){1'b1}}};
         3: return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done z=%h v=%0b dz=%0b required=no done", z, v, dz);
         end else begin
            logic [W+1:0] e;
            int c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            if ({dz, v, z} !== e) begin
               errors++;
               $display("FAIL result z=%h v=%0b dz=%0b required z=%h v=%0b dz=%0b",
                        z, v, dz, e[W-1:0], e[W], e[W+1]);
            end
            checks++;
            if (cyc != c) begin
               errors++;
               $display("FAIL latency done_at=%0d required=%0d", cyc, c);
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, req);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1; start = 1'b0; x = '0; y = '0; s = '0;
      repeat (2) @(negedge clk);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      checks++;
      if ({dz, v, z} !== '0) begin
         errors++;
         $display("FAIL reset_outputs z=%h v=%0b dz=%0b required=0", z, v, dz);
      end
      rst = 1'b0;
      @(negedge clk);

      // add overflow
`ifdef ALU_SAT_EN
      issue_k(2'b00, 18'h1FFFF, 18'h1, {1'b0, 1'b1, 18'h1FFFF}, 1);
`else
      issue_k(2'b00, 18'h1FFFF, 18'h1, {1'b0, 1'b1, 18'h20000}, 1);
`endif
      // sub, then back-to-back add in the done cycle
      issue_k(2'b01, 18'd5, 18'd7, {1'b0, 1'b0, 18'h3FFFE}, 1);
      issue_k(2'b00, 18'd2, 18'd3, {1'b0, 1'b0, 18'd5}, 1);
      // multiply
      issue_k(2'b10, 18'd300, 18'd500, {1'b0, 1'b0, 18'h249F0}, W);
`ifdef ALU_SAT_EN
      issue_k(2'b10, 18'd1000, 18'd1000, {1'b0, 1'b1, 18'h3FFFF}, W);
`else
      issue_k(2'b10, 18'd1000, 18'd1000, {1'b0, 1'b1, 18'h34240}, W);
`endif
      // divide, divide by zero
      issue_k(2'b11, 18'd100000, 18'd7, {1'b0, 1'b0, 18'd14285}, W);
      issue_k(2'b11, 18'd9, 18'd0, {1'b1, 1'b1, 18'h3FFFF}, 1);

      // start while busy is ignored
      issue_k(2'b10, 18'd123, 18'd45, {1'b0, 1'b0, 18'd5535}, W);
      repeat (2) @(negedge clk);
      start = 1'b1; s = 2'b00; x = 18'd77; y = 18'd88;
      @(negedge clk);
      start = 1'b0;

      // reset mid-division abandons the op with no done
      wait_idle();
      start = 1'b1; s = 2'b11; x = 18'd50000; y = 18'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_v", v, 1'b0);
      check_bit("rst_dz", dz, 1'b0);
      checks++;
      if (z !== '0) begin
         errors++;
         $display("FAIL rst_z actual=%h required=0", z);
      end
      issue_k(2'b00, 18'd10, 18'd20, {1'b0, 1'b0, 18'd30}, 1);

      // random traffic against the model
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         logic [W-1:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         if (op == 2'b11 && $urandom_range(0, 5) == 0) b = '0;
         issue_r(op, a, b);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
